knn_vote: RTL and testbench

KNN_VOTE -- requirements
Module: knn_vote

---
 rtl/knn_vote.sv | 127 ++++++++++++
 tb/tb_knn_vote.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// k-NN majority vote: counts one neighbour slot per cycle and reports the most frequent label.
// Optional macro KNN_VOTE_NEAREST_TIE_EN: ties go to the nearest neighbour instead of the smaller label.
module knn_vote #(
    parameter int N_NEIGHBOUR = 4,
    parameter int LABEL_W     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LABEL_W*N_NEIGHBOUR-1:0]     in_labels,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LABEL_W-1:0]                 out_label,
    output logic [$clog2(N_NEIGHBOUR+1)-1:0]   out_votes
);

    localparam int IDX_W  = (N_NEIGHBOUR > 1) ? $clog2(N_NEIGHBOUR) : 1;
    localparam int VOTE_W = $clog2(N_NEIGHBOUR + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEIGHBOUR - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [LABEL_W-1:0] slot [N_NEIGHBOUR];
    logic [IDX_W-1:0]   idx;
    logic [LABEL_W-1:0] best_label;
    logic [VOTE_W-1:0]  best_count;
    logic [LABEL_W-1:0] cur_label;
    logic [VOTE_W-1:0]  cur_count;
    logic               replace;
    logic               accept;
    logic               last;

    assign accept = in_valid && (state == IDLE);
    assign last   = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = COUNT;
            COUNT:   if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Occurrence count of the label in the slot currently under evaluation.
    always_comb begin
        cur_label = slot[idx];
        cur_count = '0;
        for (int j = 0; j < N_NEIGHBOUR; j++) begin
            if (slot[j] == cur_label) begin
                cur_count = cur_count + VOTE_W'(1);
            end
        end
    end

    always_comb begin
        replace = 1'b0;
        if (idx == '0) begin
            replace = 1'b1;
        end else if (cur_count > best_count) begin
            replace = 1'b1;
`ifdef KNN_VOTE_NEAREST_TIE_EN
        end else begin
            replace = 1'b0;
`else
        end else if ((cur_count == best_count) && (cur_label < best_label)) begin
            replace = 1'b1;
`endif
        end
    end

    // Output registers are loaded only on the final slot so they stay frozen outside DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEIGHBOUR; i++) begin
                slot[i] <= '0;
            end
            idx        <= '0;
            best_label <= '0;
            best_count <= '0;
            out_label  <= '0;
            out_votes  <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_NEIGHBOUR; i++) begin
                slot[i] <= in_labels[LABEL_W*i +: LABEL_W];
            end
            idx        <= '0;
            best_label <= '0;
            best_count <= '0;
        end else if (state == COUNT) begin
            if (replace) begin
                best_label <= cur_label;
                best_count <= cur_count;
            end
            if (last) begin
                idx       <= '0;
                out_label <= replace ? cur_label : best_label;
                out_votes <= replace ? cur_count : best_count;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Directed self-checking bench for knn_vote with N_NEIGHBOUR=4, LABEL_W=8.
// Tie expectations follow KNN_VOTE_NEAREST_TIE_EN when it is defined for the build.
module tb_knn_vote;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_labels;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_label;
    logic [2:0]  out_votes;

    int compared;
    int mismatched;

    knn_vote #(
        .N_NEIGHBOUR(4),
        .LABEL_W    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_labels(in_labels),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_label(out_label),
        .out_votes(out_votes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Presents a set from just after an edge and returns just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] labels);
        int waited;
        waited = 0;
        in_labels = labels;
        in_valid  = 1'b1;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("accept_wait", 32'(waited < 50), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_labels = 32'hFFFF_FFFF;
    endtask

    task automatic waitResult(output int latency);
        latency = 0;
        while (!out_valid && latency < 20) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [7:0] exp_tie;
        logic [7:0] exp_distinct;

`ifdef KNN_VOTE_NEAREST_TIE_EN
        exp_tie      = 8'd5;
        exp_distinct = 8'd7;
`else
        exp_tie      = 8'd2;
        exp_distinct = 8'd3;
`endif
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_labels  = '0;
        out_ready  = 1'b0;

        #2;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_label", 32'(out_label), 32'd0);
        checkOutput("rst_out_votes", 32'(out_votes), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Majority {1,1,1,2}, with latency and mid-count label changes ignored.
        applyStimulus({8'd2, 8'd1, 8'd1, 8'd1});
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("maj_early_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("maj_valid_at_4", 32'(out_valid), 32'd1);
        checkOutput("maj_label", 32'(out_label), 32'd1);
        checkOutput("maj_votes", 32'(out_votes), 32'd3);
        checkOutput("maj_in_ready_busy", 32'(in_ready), 32'd0);
        consume("maj");
        checkOutput("maj_label_hold", 32'(out_label), 32'd1);

        applyStimulus({8'd5, 8'd2, 8'd2, 8'd5});
        waitResult(lat);
        checkOutput("tie_latency", 32'(lat), 32'd4);
        checkOutput("tie_label", 32'(out_label), 32'(exp_tie));
        checkOutput("tie_votes", 32'(out_votes), 32'd2);
        consume("tie");

        applyStimulus({8'd4, 8'd9, 8'd3, 8'd7});
        waitResult(lat);
        checkOutput("distinct_latency", 32'(lat), 32'd4);
        checkOutput("distinct_label", 32'(out_label), 32'(exp_distinct));
        checkOutput("distinct_votes", 32'(out_votes), 32'd1);
        consume("distinct");

        // Backpressure: result held, new sets refused while DONE.
        applyStimulus({8'd4, 8'd6, 8'd4, 8'd4});
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'd4);
        for (int k = 0; k < 10; k++) begin
            in_valid  = k[0];
            in_labels = {8'd9, 8'd9, 8'd9, 8'(k)};
            @(posedge clk);
            #1;
            checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
            checkOutput("bp_label_stable", 32'(out_label), 32'd4);
            checkOutput("bp_votes_stable", 32'(out_votes), 32'd3);
            checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume("bp");
        @(posedge clk);
        #1;
        checkOutput("bp_no_ghost_accept", 32'(in_ready), 32'd1);

        // Reset two cycles into counting discards the set.
        applyStimulus({8'd2, 8'd2, 8'd2, 8'd2});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_votes", 32'(out_votes), 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_no_result", 32'(out_valid), 32'd0);
        applyStimulus({8'd3, 8'd3, 8'd0, 8'd0});
        waitResult(lat);
        checkOutput("postrst_latency", 32'(lat), 32'd4);
        checkOutput("postrst_label", 32'(out_label), 32'd0);
        checkOutput("postrst_votes", 32'(out_votes), 32'd2);
        consume("postrst");

        // Back-to-back with in_valid held and out_ready high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_labels = {8'd3, 8'd3, 8'd2, 8'd1};
        checkOutput("b2b_ready_first", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_labels = {8'd8, 8'd8, 8'd8, 8'd8};
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("b2b_busy_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("b2b_first_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_first_label", 32'(out_label), 32'd3);
        checkOutput("b2b_first_votes", 32'(out_votes), 32'd2);
        @(posedge clk);
        #1;
        checkOutput("b2b_idle_at_5", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b_second_accept_at_6", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        in_labels = '0;
        waitResult(lat);
        checkOutput("b2b_second_latency", 32'(lat), 32'd4);
        checkOutput("b2b_second_label", 32'(out_label), 32'd8);
        checkOutput("b2b_second_votes", 32'(out_votes), 32'd4);
        @(posedge clk);
        #1;
        checkOutput("b2b_second_consumed", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
